// File: rtl/fast_pkg.sv
// Shared types and constants for the FAST corner scan controller.
package fast_pkg;
  localparam int CIRCLE_N = 16;
  localparam int SAMPLE_N = CIRCLE_N + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EVAL, S_WRITE, S_ADVANCE, S_FINISH
  } state_t;

  // {dx, dy} as 4-bit two's complement; entry k is circle position k+1
  localparam logic [7:0] CIRCLE_OFS [CIRCLE_N] = '{
    8'h0D, 8'h1D, 8'h2E, 8'h3F, 8'h30, 8'h31, 8'h22, 8'h13,
    8'h03, 8'hF3, 8'hE2, 8'hD1, 8'hD0, 8'hDF, 8'hEE, 8'hFD
  };
endpackage

// File: rtl/fast_segment_test.sv
// Combinational FAST segment test: bright/dark masks against a saturated
// threshold band and circular contiguous-arc detection.
module fast_segment_test
  import fast_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int ARC_N = 9
) (
  input  logic [PIX_W-1:0]          i_centre,
  input  logic [CIRCLE_N*PIX_W-1:0] i_circle,
  input  logic [PIX_W-1:0]          i_thr,
  output logic                      o_corner
);
  logic [PIX_W:0]      w_hi_raw, w_lo_raw;
  logic [PIX_W-1:0]    w_hi, w_lo;
  logic [CIRCLE_N-1:0] w_bright, w_dark;

  assign w_hi_raw = {1'b0, i_centre} + {1'b0, i_thr};
  assign w_lo_raw = {1'b0, i_centre} - {1'b0, i_thr};
  assign w_hi     = w_hi_raw[PIX_W] ? '1 : w_hi_raw[PIX_W-1:0];
  assign w_lo     = w_lo_raw[PIX_W] ? '0 : w_lo_raw[PIX_W-1:0];

  always_comb begin
    w_bright = '0;
    w_dark   = '0;
    for (int i = 0; i < CIRCLE_N; i++) begin
      w_bright[i] = i_circle[i*PIX_W +: PIX_W] > w_hi;
      w_dark[i]   = i_circle[i*PIX_W +: PIX_W] < w_lo;
    end
  end

  // Doubling the mask turns the circular window into a linear one.
  function automatic logic has_arc(input logic [CIRCLE_N-1:0] m);
    logic [2*CIRCLE_N-1:0] d;
    logic                  hit;
    d   = {m, m};
    hit = 1'b0;
    for (int s = 0; s < CIRCLE_N; s++) begin
      if (&d[s +: ARC_N]) hit = 1'b1;
    end
    return hit;
  endfunction

  assign o_corner = has_arc(w_bright) | has_arc(w_dark);
endmodule

// File: rtl/fast_scan_ctrl.sv
// Full-frame FAST corner scan: fetches centre plus 16-pixel circle from SRAM2,
// runs the segment test, writes a corner flag per interior centre to SRAM4.
//
// state    | meaning
// IDLE     | waiting for start
// FETCH    | 17 reads on consecutive cycles plus one drain cycle
// EVAL     | segment test on captured samples
// WRITE    | corner flag written at centre address
// ADVANCE  | raster step to next centre or end of frame
// FINISH   | frame complete, done pulse follows
module fast_scan_ctrl
  import fast_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int PIX_W  = 8,
  parameter int ARC_N  = 9,
  parameter int BORDER = 3
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] max_x,
  input  logic [ADDR_W-1:0] max_y,
  input  logic [PIX_W-1:0]  threshold,
  input  logic [PIX_W-1:0]  SRAM_in,
  output logic              read_SRAM2,
  output logic [ADDR_W-1:0] x_addr,
  output logic [ADDR_W-1:0] y_addr,
  output logic              write_SRAM4,
  output logic [ADDR_W-1:0] x_addr4,
  output logic [ADDR_W-1:0] y_addr4,
  output logic [PIX_W-1:0]  wdata4,
  output logic              busy,
  output logic              done
);
  localparam logic [4:0]        READ_LAST  = 5'(SAMPLE_N - 1);
  localparam logic [4:0]        FETCH_LAST = 5'(SAMPLE_N);
  localparam logic [ADDR_W-1:0] W_BORDER   = ADDR_W'(BORDER);
  localparam logic [ADDR_W-1:0] W_MIN_SPAN = ADDR_W'(2*BORDER);

  state_t                    r_state, w_next;
  logic [ADDR_W-1:0]         r_cx, r_cy, r_max_x, r_max_y;
  logic [ADDR_W-1:0]         r_hx, r_hy, r_wx, r_wy;
  logic [PIX_W-1:0]          r_thr, r_wd;
  logic [4:0]                r_fidx, r_idx_d;
  logic                      r_rd_d, r_corner, r_busy, r_done;
  logic [PIX_W-1:0]          r_samp [SAMPLE_N];
  logic                      w_rd, w_wr, w_corner, w_last_x, w_last_y;
  logic [7:0]                w_ofs;
  logic [ADDR_W-1:0]         w_rx, w_ry;
  logic [CIRCLE_N*PIX_W-1:0] w_circle;

  assign w_rd     = (r_state == S_FETCH) && (r_fidx <= READ_LAST);
  assign w_wr     = (r_state == S_WRITE);
  assign w_ofs    = (r_fidx == 5'd0) ? 8'h00 : CIRCLE_OFS[4'(r_fidx - 5'd1)];
  assign w_rx     = r_cx + {{(ADDR_W-4){w_ofs[7]}}, w_ofs[7:4]};
  assign w_ry     = r_cy + {{(ADDR_W-4){w_ofs[3]}}, w_ofs[3:0]};
  assign w_last_x = (r_cx == r_max_x - W_BORDER);
  assign w_last_y = (r_cy == r_max_y - W_BORDER);

  // Addresses show the live value while strobed and the held value otherwise.
  assign read_SRAM2  = w_rd;
  assign x_addr      = w_rd ? w_rx : r_hx;
  assign y_addr      = w_rd ? w_ry : r_hy;
  assign write_SRAM4 = w_wr;
  assign x_addr4     = w_wr ? r_cx : r_wx;
  assign y_addr4     = w_wr ? r_cy : r_wy;
  assign wdata4      = w_wr ? {PIX_W{r_corner}} : r_wd;
  assign busy        = r_busy;
  assign done        = r_done;

  always_comb begin
    w_circle = '0;
    for (int i = 0; i < CIRCLE_N; i++) w_circle[i*PIX_W +: PIX_W] = r_samp[i+1];
  end

  fast_segment_test #(.PIX_W(PIX_W), .ARC_N(ARC_N)) u_seg (
    .i_centre (r_samp[0]),
    .i_circle (w_circle),
    .i_thr    (r_thr),
    .o_corner (w_corner)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = (max_x < W_MIN_SPAN || max_y < W_MIN_SPAN) ? S_FINISH : S_FETCH;
      S_FETCH:   if (r_fidx == FETCH_LAST) w_next = S_EVAL;
      S_EVAL:    w_next = S_WRITE;
      S_WRITE:   w_next = S_ADVANCE;
      S_ADVANCE: w_next = (w_last_x && w_last_y) ? S_FINISH : S_FETCH;
      S_FINISH:  w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cx     <= '0;
      r_cy     <= '0;
      r_max_x  <= '0;
      r_max_y  <= '0;
      r_thr    <= '0;
      r_hx     <= '0;
      r_hy     <= '0;
      r_wx     <= '0;
      r_wy     <= '0;
      r_wd     <= '0;
      r_fidx   <= '0;
      r_idx_d  <= '0;
      r_rd_d   <= 1'b0;
      r_corner <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      for (int i = 0; i < SAMPLE_N; i++) r_samp[i] <= '0;
    end else begin
      // SRAM data lands one cycle after the strobe.
      r_rd_d  <= w_rd;
      r_idx_d <= r_fidx;
      if (r_rd_d) r_samp[r_idx_d] <= SRAM_in;
      if (w_rd) begin
        r_hx <= w_rx;
        r_hy <= w_ry;
      end
      if (w_wr) begin
        r_wx <= r_cx;
        r_wy <= r_cy;
        r_wd <= {PIX_W{r_corner}};
      end
      r_fidx <= (r_state == S_FETCH && r_fidx != FETCH_LAST) ? r_fidx + 5'd1 : 5'd0;
      r_done <= (r_state == S_FINISH);
      case (r_state)
        S_IDLE: if (start) begin
          r_max_x <= max_x;
          r_max_y <= max_y;
          r_thr   <= threshold;
          r_cx    <= W_BORDER;
          r_cy    <= W_BORDER;
          r_busy  <= 1'b1;
        end
        S_EVAL: r_corner <= w_corner;
        S_ADVANCE: begin
          if (w_last_x) begin
            r_cx <= W_BORDER;
            if (!w_last_y) r_cy <= r_cy + ADDR_W'(1);
          end else begin
            r_cx <= r_cx + ADDR_W'(1);
          end
        end
        S_FINISH: r_busy <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fast_scan_ctrl.sv
// Self-checking bench for fast_scan_ctrl: SRAM2 image model, reference
// segment-test model and a write scoreboard.
module tb_fast_scan_ctrl;
  localparam int ARC_N = 9;
  localparam int DX [16] = '{0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
  localparam int DY [16] = '{-3, -3, -2, -1, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3};

  logic       clk = 1'b0, n_rst = 1'b0, start = 1'b0;
  logic [8:0] max_x = '0, max_y = '0;
  logic [7:0] threshold = '0, SRAM_in = '0;
  logic       read_SRAM2, write_SRAM4, busy, done;
  logic [8:0] x_addr, y_addr, x_addr4, y_addr4;
  logic [7:0] wdata4;

  always #5 clk = ~clk;

  fast_scan_ctrl dut (
    .clk(clk), .n_rst(n_rst), .start(start), .max_x(max_x), .max_y(max_y),
    .threshold(threshold), .SRAM_in(SRAM_in), .read_SRAM2(read_SRAM2),
    .x_addr(x_addr), .y_addr(y_addr), .write_SRAM4(write_SRAM4),
    .x_addr4(x_addr4), .y_addr4(y_addr4), .wdata4(wdata4), .busy(busy), .done(done)
  );

  typedef struct {int x; int y; int d;} wr_t;
  typedef struct {int c; int base; int arcv; int first; int len; int thr; int exp;} vec_t;

  wr_t        sb[$];
  wr_t        mon_e;
  vec_t       vecs[9];
  logic [7:0] img [16][16];
  int         checks = 0, failures = 0, n_reads = 0, n_writes = 0, n_done = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  always @(posedge clk) if (read_SRAM2) SRAM_in <= img[y_addr[3:0]][x_addr[3:0]];

  always @(negedge clk) begin
    if (read_SRAM2) n_reads++;
    if (done) n_done++;
    if (write_SRAM4) begin
      n_writes++;
      check("rd_during_wr", int'(read_SRAM2), 0);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual x=%0d y=%0d d=%0d required=no write",
                 x_addr4, y_addr4, wdata4);
      end else begin
        mon_e = sb.pop_front();
        check("wr_x", int'(x_addr4), mon_e.x);
        check("wr_y", int'(y_addr4), mon_e.y);
        check($sformatf("wr_data(%0d,%0d)", mon_e.x, mon_e.y), int'(wdata4), mon_e.d);
      end
    end
  end

  function automatic bit model_corner(input int cx, input int cy, input int t);
    int c, p;
    bit b[16], d[16];
    bit ab, ad, hit;
    c = img[cy][cx];
    for (int i = 0; i < 16; i++) begin
      p = img[cy+DY[i]][cx+DX[i]];
      b[i] = p > c + t;
      d[i] = p < c - t;
    end
    hit = 0;
    for (int s = 0; s < 16; s++) begin
      ab = 1;
      ad = 1;
      for (int k = 0; k < ARC_N; k++) begin
        ab &= b[(s+k)%16];
        ad &= d[(s+k)%16];
      end
      hit |= ab | ad;
    end
    return hit;
  endfunction

  task automatic push_model(input int mx, input int my, input int t);
    wr_t e;
    for (int y = 3; y <= my - 3; y++)
      for (int x = 3; x <= mx - 3; x++) begin
        e.x = x;
        e.y = y;
        e.d = model_corner(x, y, t) ? 255 : 0;
        sb.push_back(e);
      end
  endtask

  task automatic run_frame(input int mx, input int my, input int t,
                           input int exp_cyc, input int repulse);
    int cyc;
    @(negedge clk);
    max_x = 9'(mx); max_y = 9'(my); threshold = 8'(t); start = 1'b1;
    n_reads = 0; n_writes = 0; n_done = 0;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    check("busy_after_start", int'(busy), 1);
    while (!done && cyc < exp_cyc + 40) begin
      if (cyc == repulse) begin
        start = 1'b1;
        max_x = 9'd15;
        max_y = 9'd15;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("done_cycle", cyc, exp_cyc);
    check("busy_at_done", int'(busy), 0);
    @(negedge clk);
    check("done_one_cycle", int'(done), 0);
    check("pending_writes", sb.size(), 0);
    sb.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_strobes"}, int'({read_SRAM2, write_SRAM4, busy, done}), 0);
    check({tag, "_rd_addr"}, int'({x_addr, y_addr}), 0);
    check({tag, "_wr_addr"}, int'({x_addr4, y_addr4}), 0);
    check({tag, "_wdata"}, int'(wdata4), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wr_t e;
    int  pos;
    //            c    base arcv first len thr exp
    vecs[0] = '{ 50,  50, 100,  1,  9, 20, 255};
    vecs[1] = '{ 50,  50, 100,  1,  8, 20,   0};
    vecs[2] = '{100, 100,   0, 13,  9, 20, 255};
    vecs[3] = '{100, 100, 120,  1,  9, 20,   0};
    vecs[4] = '{250, 255, 255,  1, 16, 20,   0};
    vecs[5] = '{100, 100, 121,  1, 16, 20, 255};
    vecs[6] = '{100, 100,  79,  8,  9, 20, 255};
    vecs[7] = '{100, 100,  79,  8,  8, 20,   0};
    vecs[8] = '{100, 100, 101,  5,  9,  0, 255};

    for (int y = 0; y < 16; y++) for (int x = 0; x < 16; x++) img[y][x] = 8'd0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    n_rst = 1'b1;

    // uniform 16x16 frame
    for (int y = 0; y < 16; y++) for (int x = 0; x < 16; x++) img[y][x] = 8'd77;
    push_model(15, 15, 10);
    run_frame(15, 15, 10, 2102, 0);
    check("uniform_writes", n_writes, 100);
    check("uniform_reads", n_reads, 1700);

    // single-centre 7x7 vectors
    foreach (vecs[v]) begin
      for (int y = 0; y < 7; y++) for (int x = 0; x < 7; x++) img[y][x] = 8'($urandom_range(0, 255));
      img[3][3] = 8'(vecs[v].c);
      for (int i = 1; i <= 16; i++) begin
        pos = (i - vecs[v].first + 16) % 16;
        img[3+DY[i-1]][3+DX[i-1]] = 8'((pos < vecs[v].len) ? vecs[v].arcv : vecs[v].base);
      end
      e.x = 3; e.y = 3; e.d = vecs[v].exp;
      sb.push_back(e);
      run_frame(6, 6, vecs[v].thr, 23, 0);
      check($sformatf("vec%0d_writes", v), n_writes, 1);
      check($sformatf("vec%0d_reads", v), n_reads, 17);
    end

    // too-small frames and start while busy
    run_frame(5, 5, 10, 2, 1);
    check("small_reads", n_reads, 0);
    check("small_writes", n_writes, 0);
    run_frame(15, 5, 10, 2, 0);
    check("short_y_writes", n_writes, 0);
    push_model(6, 6, 20);
    run_frame(6, 6, 20, 23, 10);
    check("restart_ignored_writes", n_writes, 1);

    // reset during first FETCH, then a full frame with planted corners
    for (int y = 0; y < 16; y++) for (int x = 0; x < 16; x++) img[y][x] = 8'($urandom_range(90, 110));
    img[6][6]  = 8'd0;
    img[10][9] = 8'd255;
    img[12][4] = 8'd250;
    @(negedge clk);
    max_x = 9'd15; max_y = 9'd15; threshold = 8'd15; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("fetch_active", int'(read_SRAM2), 1);
    #2 n_rst = 1'b0;
    #1 check_all_zero("abort");
    n_done = 0;
    n_writes = 0;
    n_reads = 0;
    repeat (5) @(negedge clk);
    check("abort_no_done", n_done, 0);
    check("abort_no_access", n_reads + n_writes, 0);
    n_rst = 1'b1;
    push_model(15, 15, 15);
    run_frame(15, 15, 15, 2102, 0);
    check("post_reset_writes", n_writes, 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fast_scan_ctrl.md
FAST_SCAN_CTRL -- requirements
Module: fast_scan_ctrl

Interface
REQ-001 Parameter ADDR_W, default 9, width of x/y coordinates and image-size inputs.
REQ-002 Parameter PIX_W, default 8, pixel width.
REQ-003 Parameter ARC_N, default 9, minimum contiguous circle arc for a corner (legal 9..12).
REQ-004 Parameter BORDER, default 3, fixed at circle radius; centres closer than BORDER to any edge are skipped.
REQ-005 clk  in  1  single clock; all logic rising-edge.
REQ-006 n_rst  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  one-cycle pulse; begins a full-frame scan.
REQ-008 max_x, max_y  in  ADDR_W  inclusive max coordinates; latched on accepted start.
REQ-009 threshold  in  PIX_W  FAST intensity threshold t; latched on accepted start.
REQ-010 SRAM_in  in  PIX_W  read data from SRAM2; valid the cycle after read_SRAM2.
REQ-011 read_SRAM2, x_addr, y_addr  out  1/ADDR_W/ADDR_W  SRAM2 read strobe and address.
REQ-012 write_SRAM4, x_addr4, y_addr4, wdata4  out  1/ADDR_W/ADDR_W/PIX_W  SRAM4 write strobe, address, data.
REQ-013 busy  out  1  high from accepted start until done.
REQ-014 done  out  1  one-cycle pulse at end of frame.

Function
REQ-015 FSM states IDLE, FETCH, EVAL, WRITE, ADVANCE, FINISH; start accepted only in IDLE, ignored otherwise.
REQ-016 On accepted start: if max_x < 2*BORDER or max_y < 2*BORDER, go to FINISH with zero reads and writes; else centre := (BORDER, BORDER), go to FETCH.
REQ-017 FETCH issues 17 reads on 17 consecutive cycles: index 0 = centre, indices 1..16 = circle offsets (0,-3),(1,-3),(2,-2),(3,-1),(3,0),(3,1),(2,2),(1,3),(0,3),(-1,3),(-2,2),(-3,1),(-3,0),(-3,-1),(-2,-2),(-1,-3) (dx,dy).
REQ-018 SRAM_in captured one cycle after each strobe into a 17-entry sample register; FETCH lasts 18 cycles (17 issue + 1 drain).
REQ-019 EVAL (1 cycle): bright[i] = p_i > c + t, dark[i] = p_i < c - t, computed in PIX_W+1 bits with c+t saturated at all-ones and c-t at zero; equality is neither.
REQ-020 Corner if bright or dark mask contains ARC_N contiguous set bits, circularly (index 16 adjacent to index 1).
REQ-021 WRITE (1 cycle): write_SRAM4=1, addr4 = centre, wdata4 = all-ones if corner else zero.
REQ-022 ADVANCE: raster order, x increments to max_x-BORDER, then x := BORDER, y increments; after (max_x-BORDER, max_y-BORDER) go to FINISH.
REQ-023 Per-centre cost exactly 21 cycles (18 FETCH + EVAL + WRITE + ADVANCE); frame cost (W-6)(H-6)*21 + 2 cycles with W=max_x+1, H=max_y+1.
REQ-024 FINISH: done=1 for one cycle, busy drops same cycle, return to IDLE.
REQ-025 Border pixels never written; SRAM4 clearing is outside this block.
REQ-026 read_SRAM2 and write_SRAM4 never high in the same cycle; addresses hold last value when strobes low.

Reset
REQ-027 n_rst low: state IDLE, all strobes, busy, done 0, all addresses, wdata4, samples and latched config 0.
REQ-028 Reset mid-frame aborts immediately; no further reads or writes; no done pulse.

Structure
REQ-029 Package fast_pkg holds state enum, 16-entry circle offset table, circle size constant 16.
REQ-030 Sub-module fast_segment_test: combinational bright/dark masks and circular arc detection, parameterised PIX_W, ARC_N.
REQ-031 fast_scan_ctrl owns FSM, position counters, fetch index counter, sample registers.

Verification
REQ-032 Uniform 16x16 image, t=10, start -> 100 writes all 0x00, done at cycle 2102 after start.
REQ-033 Centre 50, circle idx 1..9 = 100, rest 50, t=20 -> 0xFF; idx 1..8 only -> 0x00.
REQ-034 Wrap arc idx 13..16,1..5 = 0 (dark), centre 100, t=20 -> 0xFF.
REQ-035 Centre 100, t=20, nine circle pixels exactly 120 -> 0x00 (equality not bright); centre 250, t=20, circle 255 -> 0x00 (saturation).
REQ-036 max_x=max_y=5, start -> no read/write strobes, done 2 cycles after start; start during busy ignored.
REQ-037 n_rst asserted during FETCH of first centre -> all outputs 0 immediately, no done, new start runs full frame correctly.
